// File: rtl/vx_warp_ibuffer_pkg.sv
// Shared types and sizing helpers for the per-slot warp instruction buffer.
package vx_warp_ibuffer_pkg;

    localparam int ISSUE_RATIO   = 4;
    localparam int PERF_CTR_BITS = 44;
    localparam int IBUF_DATAW    = 128;

    // Decoded instruction as handed from decode to the scoreboard input.
    typedef struct packed {
        logic [IBUF_DATAW-1:0] payload;
    } ibuffer_data_t;

    // Clamp a size to at least 1 so degenerate configurations still elaborate.
    function automatic int up(input int x);
        return (x > 0) ? x : 1;
    endfunction

endpackage

// File: rtl/vx_warp_ibuffer_rr_arbiter.sv
// Round-robin pick among requesting warps, with a lock that freezes the grant
// while the downstream consumer is stalling.
module vx_warp_ibuffer_rr_arbiter
    import vx_warp_ibuffer_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req_i,
    input  logic             lock_i,
    input  logic             fire_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] sel_o
);

    logic [IDX_W-1:0] rr_q, rr_d;
    logic [IDX_W-1:0] sel_q, sel_d;
    logic             locked_q, locked_d;
    logic [IDX_W-1:0] pick;

    // First requester strictly after rr, wrapping modulo N.
    always_comb begin
        logic             found;
        logic [IDX_W-1:0] idx;
        pick  = rr_q;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= N; i++) begin
            idx = IDX_W'((int'(rr_q) + i) % N);
            if (!found && req_i[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    assign valid_o = |req_i;
    assign sel_o   = locked_q ? sel_q : pick;

    // Next-state: a completed transfer advances rr and unlocks; a stall locks.
    always_comb begin
        rr_d     = rr_q;
        sel_d    = sel_q;
        locked_d = locked_q;
        if (fire_i) begin
            rr_d     = sel_o;
            locked_d = 1'b0;
        end else if (lock_i) begin
            sel_d    = sel_o;
            locked_d = 1'b1;
        end
    end

    // Arbiter state; reset makes warp 0 the first candidate.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q     <= IDX_W'(N - 1);
            sel_q    <= '0;
            locked_q <= 1'b0;
        end else begin
            rr_q     <= rr_d;
            sel_q    <= sel_d;
            locked_q <= locked_d;
        end
    end

endmodule

// File: rtl/vx_warp_ibuffer.sv
// Per-issue-slot instruction buffer: one small FIFO per warp, round-robin
// presentation to the scoreboard over a valid/ready handshake.
module vx_warp_ibuffer
    import vx_warp_ibuffer_pkg::*;
#(
    parameter  int NUM_WARPS = up(ISSUE_RATIO),
    parameter  int DEPTH     = 4,
    parameter  int DATAW     = $bits(ibuffer_data_t),
    localparam int WIS_W     = up($clog2(NUM_WARPS)),
    localparam int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [WIS_W-1:0]           in_wis,
    input  logic [DATAW-1:0]           in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [WIS_W-1:0]           out_wis,
    output logic [DATAW-1:0]           out_data,
    input  logic                       out_ready,
    output logic [NUM_WARPS*CNT_W-1:0] warp_count,
    output logic [PERF_CTR_BITS-1:0]   perf_empty_cycles
);

    localparam int PTR_W = $clog2(DEPTH);

    logic                 push, pop;
    logic [WIS_W-1:0]     sel;
    logic [NUM_WARPS-1:0] nonempty;
    logic [CNT_W-1:0]     counts [NUM_WARPS];
    logic [DATAW-1:0]     heads  [NUM_WARPS];
    logic [PERF_CTR_BITS-1:0] perf_q, perf_d;

    // No full-bypass: readiness comes only from the registered count.
    assign in_ready  = (counts[in_wis] != CNT_W'(DEPTH));
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_wis   = sel;
    assign out_data  = heads[sel];

    vx_warp_ibuffer_rr_arbiter #(
        .N     (NUM_WARPS),
        .IDX_W (WIS_W)
    ) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req_i   (nonempty),
        .lock_i  (out_valid && !out_ready),
        .fire_i  (pop),
        .valid_o (out_valid),
        .sel_o   (sel)
    );

    for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
        logic [DATAW-1:0] mem_q [DEPTH];
        logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
        logic [CNT_W-1:0] count_q, count_d;
        logic             push_w, pop_w;

        assign push_w = push && (in_wis == WIS_W'(w));
        assign pop_w  = pop && (sel == WIS_W'(w));

        // Pointer and occupancy update; simultaneous push/pop keeps the count.
        always_comb begin
            head_d  = head_q;
            tail_d  = tail_q;
            count_d = count_q;
            if (push_w) tail_d = tail_q + PTR_W'(1);
            if (pop_w)  head_d = head_q + PTR_W'(1);
            case ({push_w, pop_w})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end

        // Queue control state.
        always_ff @(posedge clk) begin
            if (reset) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                head_q  <= head_d;
                tail_q  <= tail_d;
                count_q <= count_d;
            end
        end

        // Payload storage; contents are meaningless until counted as valid.
        always_ff @(posedge clk) begin
            if (push_w) mem_q[tail_q] <= in_data;
        end

        assign nonempty[w]                      = (count_q != '0);
        assign counts[w]                        = count_q;
        assign heads[w]                         = mem_q[head_q];
        assign warp_count[w*CNT_W +: CNT_W]     = count_q;
    end

    // Count cycles in which every queue is empty.
    always_comb begin
        perf_d = perf_q;
        if (nonempty == '0) perf_d = perf_q + PERF_CTR_BITS'(1);
    end

    // Performance counter register.
    always_ff @(posedge clk) begin
        if (reset) perf_q <= '0;
        else       perf_q <= perf_d;
    end

    assign perf_empty_cycles = perf_q;

`ifdef SIMULATION
    // Handshake sanity: never pop an empty queue or push a full one.
    always @(posedge clk) begin
        if (!reset) begin
            assert (!(pop && counts[sel] == '0))
                else $error("pop from empty queue %0d", sel);
            assert (!(push && counts[in_wis] == CNT_W'(DEPTH)))
                else $error("push to full queue %0d", in_wis);
        end
    end
`endif

endmodule

// File: tb/tb_vx_warp_ibuffer.sv
// Directed bench for vx_warp_ibuffer with four warps and depth-4 queues.
module tb_vx_warp_ibuffer;
    import vx_warp_ibuffer_pkg::*;

    localparam int NW    = 4;
    localparam int DEPTH = 4;
    localparam int DATAW = 128;
    localparam int WIS_W = 2;
    localparam int CNT_W = 3;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    in_valid;
    logic [WIS_W-1:0]        in_wis;
    logic [DATAW-1:0]        in_data;
    logic                    in_ready;
    logic                    out_valid;
    logic [WIS_W-1:0]        out_wis;
    logic [DATAW-1:0]        out_data;
    logic                    out_ready;
    logic [NW*CNT_W-1:0]     warp_count;
    logic [PERF_CTR_BITS-1:0] perf_empty_cycles;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vx_warp_ibuffer #(.NUM_WARPS(NW), .DEPTH(DEPTH), .DATAW(DATAW)) dut (
        .clk               (clk),
        .reset             (reset),
        .in_valid          (in_valid),
        .in_wis            (in_wis),
        .in_data           (in_data),
        .in_ready          (in_ready),
        .out_valid         (out_valid),
        .out_wis           (out_wis),
        .out_data          (out_data),
        .out_ready         (out_ready),
        .warp_count        (warp_count),
        .perf_empty_cycles (perf_empty_cycles)
    );

    function automatic int cnt(input int w);
        return int'(warp_count[w*CNT_W +: CNT_W]);
    endfunction

    // Advance one clock; inputs are driven and outputs sampled at negedge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_one(input int w, input int d);
        in_valid = 1'b1;
        in_wis   = WIS_W'(w);
        in_data  = DATAW'(d);
        tick();
        in_valid = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        in_wis    = '0;
        in_data   = '0;
        out_ready = 1'b0;
        reset     = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %0b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %0b want 1", in_ready); end
        checks++; if (warp_count !== '0) begin errors++; $display("FAIL rst_warp_count got %0h want 0", warp_count); end
        checks++; if (perf_empty_cycles !== '0) begin errors++; $display("FAIL rst_perf got %0d want 0", perf_empty_cycles); end
    endtask

    task automatic test_latency();
        do_reset();
        push_one(2, 'hA1);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lat_valid got %0b want 1", out_valid); end
        checks++; if (out_wis !== 2'd2) begin errors++; $display("FAIL lat_wis got %0d want 2", out_wis); end
        checks++; if (out_data !== DATAW'('hA1)) begin errors++; $display("FAIL lat_data got %0h want a1", out_data); end
        checks++; if (cnt(2) !== 1) begin errors++; $display("FAIL lat_cnt2 got %0d want 1", cnt(2)); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        checks++; if (cnt(2) !== 0) begin errors++; $display("FAIL lat_cnt2_pop got %0d want 0", cnt(2)); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_valid_pop got %0b want 0", out_valid); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 4; i++) push_one(0, 'h10 + i);
        in_wis = 2'd0;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %0b want 0", in_ready); end
        checks++; if (cnt(0) !== 4) begin errors++; $display("FAIL full_cnt got %0d want 4", cnt(0)); end
        in_wis = 2'd1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_other_ready got %0b want 1", in_ready); end
        push_one(0, 'hFF);
        checks++; if (cnt(0) !== 4) begin errors++; $display("FAIL full_drop_cnt got %0d want 4", cnt(0)); end
        out_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_valid !== 1'b1 || out_wis !== 2'd0 || out_data !== DATAW'('h10 + i)) begin
                errors++; $display("FAIL full_drain%0d got v=%0b w=%0d d=%0h want v=1 w=0 d=%0h", i, out_valid, out_wis, out_data, 'h10 + i);
            end
            tick();
            #1;
        end
        out_ready = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_drained_valid got %0b want 0", out_valid); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_w [6];
        int         exp_d [6];
        exp_w[0] = 2'd0; exp_w[1] = 2'd1; exp_w[2] = 2'd3;
        exp_w[3] = 2'd0; exp_w[4] = 2'd1; exp_w[5] = 2'd3;
        exp_d[0] = 'h00; exp_d[1] = 'h10; exp_d[2] = 'h30;
        exp_d[3] = 'h01; exp_d[4] = 'h11; exp_d[5] = 'h31;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            push_one(0, 'h00 + i);
            push_one(1, 'h10 + i);
            push_one(3, 'h30 + i);
        end
        out_ready = 1'b1;
        #1;
        for (int i = 0; i < 6; i++) begin
            checks++; if (out_valid !== 1'b1 || out_wis !== exp_w[i] || out_data !== DATAW'(exp_d[i])) begin
                errors++; $display("FAIL rr_pop%0d got v=%0b w=%0d d=%0h want v=1 w=%0d d=%0h", i, out_valid, out_wis, out_data, exp_w[i], exp_d[i]);
            end
            tick();
            #1;
        end
        out_ready = 1'b0;
        #1;
    endtask

    task automatic test_stall_lock();
        do_reset();
        push_one(0, 'hB0);
        push_one(1, 'hB1);
        for (int i = 0; i < 5; i++) begin
            checks++; if (out_valid !== 1'b1 || out_wis !== 2'd0 || out_data !== DATAW'('hB0)) begin
                errors++; $display("FAIL stall_hold%0d got v=%0b w=%0d d=%0h want v=1 w=0 d=b0", i, out_valid, out_wis, out_data);
            end
            tick();
            #1;
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        checks++; if (out_wis !== 2'd1 || out_data !== DATAW'('hB1)) begin
            errors++; $display("FAIL stall_next got w=%0d d=%0h want w=1 d=b1", out_wis, out_data);
        end
        // A higher-priority warp arriving during a stall must not steal the slot.
        do_reset();
        push_one(1, 'hC1);
        push_one(0, 'hC0);
        checks++; if (out_wis !== 2'd1 || out_data !== DATAW'('hC1)) begin
            errors++; $display("FAIL lock_keep got w=%0d d=%0h want w=1 d=c1", out_wis, out_data);
        end
    endtask

    task automatic test_same_warp();
        do_reset();
        push_one(1, 'hD0);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_wis    = 2'd1;
        in_data   = DATAW'('hD1);
        #1;
        checks++; if (in_ready !== 1'b1 || out_wis !== 2'd1 || out_data !== DATAW'('hD0)) begin
            errors++; $display("FAIL same_pre got rdy=%0b w=%0d d=%0h want rdy=1 w=1 d=d0", in_ready, out_wis, out_data);
        end
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        checks++; if (cnt(1) !== 1) begin errors++; $display("FAIL same_cnt got %0d want 1", cnt(1)); end
        checks++; if (out_valid !== 1'b1 || out_wis !== 2'd1 || out_data !== DATAW'('hD1)) begin
            errors++; $display("FAIL same_next got v=%0b w=%0d d=%0h want v=1 w=1 d=d1", out_valid, out_wis, out_data);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            push_one(0, 'hE0 + i);
            push_one(2, 'hE8 + i);
        end
        checks++; if (cnt(0) !== 3 || cnt(2) !== 3) begin errors++; $display("FAIL mid_fill got c0=%0d c2=%0d want 3 3", cnt(0), cnt(2)); end
        reset = 1'b1;
        tick();
        reset  = 1'b0;
        in_wis = 2'd0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %0b want 0", out_valid); end
        checks++; if (warp_count !== '0) begin errors++; $display("FAIL mid_counts got %0h want 0", warp_count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready got %0b want 1", in_ready); end
        for (int i = 0; i < 3; i++) tick();
        #1;
        checks++; if (perf_empty_cycles !== PERF_CTR_BITS'(3)) begin errors++; $display("FAIL mid_perf got %0d want 3", perf_empty_cycles); end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_wis    = '0;
        in_data   = '0;
        out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_latency();
        test_full();
        test_round_robin();
        test_stall_lock();
        test_same_warp();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
